// File: rtl/rng_pkg.sv
// Shared constants and the 80-to-32 bit state fold used by the RNG word FIFO.
package rng_pkg;

  localparam int RNG_STATE_W     = 80;
  localparam int WORD_W          = 32;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_HARVEST_INT = 8;
  localparam int DEF_REP_LIMIT   = 3;

  // Upper 16 state bits are zero-extended so every generator bit reaches the word.
  function automatic logic [WORD_W-1:0] fold(input logic [RNG_STATE_W-1:0] s);
    return s[31:0] ^ s[63:32] ^ {16'h0, s[79:64]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; the caller qualifies push and pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

  assign rvalid = (level != '0);
  assign rdata  = rvalid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rng_word_fifo.sv
// Periodically harvests folded generator state into a FIFO, guarded by a
// repetition health test and a sticky overflow flag.
module rng_word_fifo #(
  parameter int WORD_W      = rng_pkg::WORD_W,
  parameter int DEPTH       = rng_pkg::DEF_DEPTH,
  parameter int HARVEST_INT = rng_pkg::DEF_HARVEST_INT,
  parameter int REP_LIMIT   = rng_pkg::DEF_REP_LIMIT,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_rng_initdone,
  input  logic [79:0]       i_rng_state,
  input  logic              i_clr,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [LW-1:0]     o_level,
  output logic              o_ovf,
  output logic              o_hlth_err
);

  import rng_pkg::*;

  localparam logic [7:0]    HV_LAST  = 8'(HARVEST_INT - 1);
  localparam logic [3:0]    REP_LIM  = 4'(REP_LIMIT);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic              run;
  logic [7:0]        hcnt;
  logic              hv;
  logic [WORD_W-1:0] fw;
  logic [WORD_W-1:0] prev_fw;
  logic [3:0]        rep_cnt;
  logic [3:0]        rep_next;
  logic              rep_fail;
  logic              word_ok;
  logic              pop;
  logic              push;
  logic              full;

  assign run = i_en & i_rng_initdone;
  assign hv  = run && (hcnt == HV_LAST);
  assign fw  = fold(i_rng_state);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hcnt <= '0;
    end else if (hcnt == HV_LAST) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_comb begin
    rep_next = 4'd1;
    if (fw == prev_fw) begin
      rep_next = (rep_cnt == 4'd15) ? 4'd15 : rep_cnt + 1'b1;
    end
  end

  assign rep_fail = rep_next >= REP_LIM;
  assign word_ok  = hv && !o_hlth_err && !rep_fail;
  assign pop      = o_rvalid && i_rready;
  assign full     = (o_level == FULL_LVL);
  assign push     = word_ok && (!full || pop);

  // prev_fw keeps tracking harvests even while pushes are blocked or cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_fw <= '0;
    end else if (hv) begin
      prev_fw <= fw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt    <= '0;
      o_ovf      <= 1'b0;
      o_hlth_err <= 1'b0;
    end else if (i_clr) begin
      rep_cnt    <= '0;
      o_ovf      <= 1'b0;
      o_hlth_err <= 1'b0;
    end else begin
      if (hv) begin
        rep_cnt <= rep_next;
      end
      if (hv && rep_fail) begin
        o_hlth_err <= 1'b1;
      end
      if (word_ok && full && !pop) begin
        o_ovf <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fw),
    .pop   (pop),
    .rdata (o_rdata),
    .rvalid(o_rvalid),
    .level (o_level)
  );

endmodule

// File: tb/tb_rng_word_fifo.sv
// Directed scoreboard bench for rng_word_fifo with default parameters.
module tb_rng_word_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_rng_initdone;
  logic [79:0] i_rng_state;
  logic        i_clr;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        i_rready;
  logic [2:0]  o_level;
  logic        o_ovf;
  logic        o_hlth_err;

  int          checks = 0;
  int          errors = 0;
  logic        counting = 1'b0;
  logic [31:0] exp_q[$];

  rng_word_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_rng_initdone(i_rng_initdone),
    .i_rng_state   (i_rng_state),
    .i_clr         (i_clr),
    .o_rdata       (o_rdata),
    .o_rvalid      (o_rvalid),
    .i_rready      (i_rready),
    .o_level       (o_level),
    .o_ovf         (o_ovf),
    .o_hlth_err    (o_hlth_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (counting) i_rng_state = i_rng_state + 80'd1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Holds a state for n cycles; optionally raises i_clr on the final cycle.
  task automatic applyStimulus(input logic [79:0] st, input int n, input logic clrLast);
    i_rng_state = st;
    for (int i = 0; i < n; i++) begin
      if (clrLast && i == n - 1) i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
    end
  endtask

  // Monitor: every accepted head word is compared against the scoreboard.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && o_rvalid === 1'b1 && i_rready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %h expected none", o_rdata);
        end else begin
          w = exp_q.pop_front();
          checkOutput("rdata", o_rdata, w);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_en = 1'b0; i_rng_initdone = 1'b0; i_rng_state = '0;
    i_clr = 1'b0; i_rready = 1'b0;
    tick();
    tick();
    checkOutput("rst_level", 32'(o_level), 32'd0);
    checkOutput("rst_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("rst_rdata", o_rdata, 32'd0);
    checkOutput("rst_ovf", 32'(o_ovf), 32'd0);
    checkOutput("rst_hlth", 32'(o_hlth_err), 32'd0);

    $display("[TB] counting state stream");
    i_en = 1'b1; i_rng_initdone = 1'b1; i_rready = 1'b1;
    resetDut();
    i_rng_state = 80'h0001_00000002_00000000;
    counting = 1'b1;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h14);
    repeat (26) tick();
    counting = 1'b0;
    checkOutput("count_hlth", 32'(o_hlth_err), 32'd0);
    checkOutput("count_level", 32'(o_level), 32'd0);

    $display("[TB] overflow and clear priority");
    i_rready = 1'b0;
    resetDut();
    exp_q.push_back(32'h11111111); applyStimulus(80'h11111111, 8, 1'b0);
    exp_q.push_back(32'h22222222); applyStimulus(80'h22222222, 8, 1'b0);
    exp_q.push_back(32'h33333333); applyStimulus(80'h33333333, 8, 1'b0);
    exp_q.push_back(32'h44444444); applyStimulus(80'h44444444, 8, 1'b0);
    checkOutput("full_level", 32'(o_level), 32'd4);
    checkOutput("full_head", o_rdata, 32'h11111111);
    applyStimulus(80'h55555555, 8, 1'b1);
    checkOutput("ovf_clr_wins", 32'(o_ovf), 32'd0);
    applyStimulus(80'h66666666, 8, 1'b0);
    checkOutput("ovf_set", 32'(o_ovf), 32'd1);
    checkOutput("ovf_level", 32'(o_level), 32'd4);
    i_rready = 1'b1;
    repeat (6) tick();
    checkOutput("ovf_drained", 32'(o_level), 32'd0);

    $display("[TB] push and pop while full");
    i_rready = 1'b0;
    resetDut();
    exp_q.push_back(32'hA0); applyStimulus(80'hA0, 8, 1'b0);
    exp_q.push_back(32'hB0); applyStimulus(80'hB0, 8, 1'b0);
    exp_q.push_back(32'hC0); applyStimulus(80'hC0, 8, 1'b0);
    exp_q.push_back(32'hD0); applyStimulus(80'hD0, 8, 1'b0);
    exp_q.push_back(32'h88882345);
    applyStimulus(80'hABCD_12345678_9ABCDEF0, 7, 1'b0);
    i_rready = 1'b1;
    tick();
    i_rready = 1'b0;
    checkOutput("pp_level", 32'(o_level), 32'd4);
    checkOutput("pp_ovf", 32'(o_ovf), 32'd0);
    checkOutput("pp_head", o_rdata, 32'hB0);
    i_rready = 1'b1;
    repeat (6) tick();
    checkOutput("pp_drained", 32'(o_level), 32'd0);

    $display("[TB] repetition health test");
    resetDut();
    exp_q.push_back(32'h1); applyStimulus(80'h1, 8, 1'b0);
    exp_q.push_back(32'h1); applyStimulus(80'h1, 8, 1'b0);
    applyStimulus(80'h1, 8, 1'b0);
    checkOutput("hlth_set", 32'(o_hlth_err), 32'd1);
    checkOutput("hlth_level", 32'(o_level), 32'd0);
    applyStimulus(80'h55, 8, 1'b0);
    checkOutput("hlth_sticky", 32'(o_hlth_err), 32'd1);
    checkOutput("hlth_blocked", 32'(o_level), 32'd0);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    checkOutput("clr_hlth", 32'(o_hlth_err), 32'd0);
    checkOutput("clr_ovf", 32'(o_ovf), 32'd0);
    exp_q.push_back(32'h55); applyStimulus(80'h55, 7, 1'b0);
    exp_q.push_back(32'h66); applyStimulus(80'h66, 8, 1'b0);
    repeat (2) tick();
    checkOutput("resume_hlth", 32'(o_hlth_err), 32'd0);

    $display("[TB] reset mid-operation and harvest gating");
    i_rready = 1'b0;
    resetDut();
    exp_q.push_back(32'h0F); applyStimulus(80'h0F, 8, 1'b0);
    exp_q.push_back(32'h1F); applyStimulus(80'h1F, 8, 1'b0);
    exp_q.push_back(32'h2F); applyStimulus(80'h2F, 8, 1'b0);
    checkOutput("pre_rst_level", 32'(o_level), 32'd3);
    resetDut();
    checkOutput("mid_rst_level", 32'(o_level), 32'd0);
    checkOutput("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("mid_rst_rdata", o_rdata, 32'd0);
    i_rng_initdone = 1'b0;
    applyStimulus(80'h12345, 20, 1'b0);
    checkOutput("nodone_level", 32'(o_level), 32'd0);
    i_rng_initdone = 1'b1;
    exp_q.push_back(32'h77); applyStimulus(80'h77, 8, 1'b0);
    checkOutput("done_level", 32'(o_level), 32'd1);
    checkOutput("done_head", o_rdata, 32'h77);
    exp_q.push_back(32'h88);
    applyStimulus(80'h88, 4, 1'b0);
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    applyStimulus(80'h88, 7, 1'b0);
    checkOutput("restart_no_hv", 32'(o_level), 32'd1);
    tick();
    checkOutput("restart_hv", 32'(o_level), 32'd2);
    i_rready = 1'b1;
    repeat (4) tick();
    checkOutput("final_level", 32'(o_level), 32'd0);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
